// File: rtl/gpu_ctrl_pkg.sv
// gpu_ctrl_pkg: shared constants and types for the vector pipeline control logic.
package gpu_ctrl_pkg;
    localparam int NREGS = 16;
    localparam int AW = 4;
    localparam int CW = 2;
    localparam logic [3:0] PC_REG = 4'd15;
    typedef struct packed {
        logic       valid;
        logic [3:0] wa;
    } sb_entry_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: pending-write count for one register; net delta of -2..+1 applied per edge.
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec_retire,
    input  logic          dec_kill,
    output logic [CW-1:0] cnt,
    output logic          nonzero
);
    logic [CW:0] nxt;
    // Extra MSB flags both wrap below zero and growth past the CW-bit range.
    assign nxt = {1'b0, cnt} + (CW+1)'(inc) - (CW+1)'(dec_retire) - (CW+1)'(dec_kill);
    assign nonzero = |cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else begin
            assert (!nxt[CW]);
            cnt <= nxt[CW-1:0];
        end
    end
endmodule

// File: rtl/vec_scoreboard.sv
// vec_scoreboard: RAW hazard stall/flush control for decode using an E/M/W shadow tag pipe.
module vec_scoreboard #(
    parameter int NREGS = 16,
    parameter int AW = 4,
    parameter int CW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidD,
    input  logic [AW-1:0]    ra1D,
    input  logic [AW-1:0]    ra2D,
    input  logic             Use1D,
    input  logic             Use2D,
    input  logic             RegWriteD,
    input  logic [AW-1:0]    wa3D,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [NREGS-1:0] Busy
);
    import gpu_ctrl_pkg::*;
    sb_entry_t e_q, m_q, w_q;
    logic [CW-1:0] cnt [NREGS];
    logic hazard, issue;
    // The write sitting in W lands in the register file this cycle, so it is discounted.
    function automatic logic hz(input logic [AW-1:0] ra);
        return ra != PC_REG && cnt[ra] != CW'(w_q.valid && w_q.wa == ra);
    endfunction
    assign hazard = ValidD && ((Use1D && hz(ra1D)) || (Use2D && hz(ra2D)));
    assign issue = ValidD && RegWriteD && wa3D != PC_REG && !hazard && !BranchTakenE;
    assign StallF = hazard && !BranchTakenE;
    assign StallD = StallF;
    assign FlushD = BranchTakenE;
    assign FlushE = hazard || BranchTakenE;
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= BranchTakenE ? '0 : e_q;
            e_q <= {issue, wa3D};
        end
    end
    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        sb_counter #(.CW(CW)) u_cnt (
            .clk(clk),
            .reset(reset),
            .inc(issue && wa3D == AW'(r)),
            .dec_retire(w_q.valid && w_q.wa == AW'(r)),
            .dec_kill(BranchTakenE && e_q.valid && e_q.wa == AW'(r)),
            .cnt(cnt[r]),
            .nonzero(Busy[r])
        );
    end
endmodule

// File: tb/tb_vec_scoreboard.sv
// tb_vec_scoreboard: directed hazard scenarios with queued expectations checked by a monitor.
module tb_vec_scoreboard;
    logic clk = 0, reset = 1;
    logic ValidD = 0, Use1D = 0, Use2D = 0, RegWriteD = 0, BranchTakenE = 0;
    logic [3:0] ra1D = 0, ra2D = 0, wa3D = 0;
    logic StallF, StallD, FlushD, FlushE;
    logic [15:0] Busy;
    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;
    vec_scoreboard dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .ra1D(ra1D), .ra2D(ra2D),
        .Use1D(Use1D), .Use2D(Use2D), .RegWriteD(RegWriteD), .wa3D(wa3D),
        .BranchTakenE(BranchTakenE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .Busy(Busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({StallF, StallD, FlushD, FlushE, Busy} !== e.v) begin
                fails++;
                $display("FAIL %s: {StallF,StallD,FlushD,FlushE,Busy} got %h expected %h",
                         e.nm, {StallF, StallD, FlushD, FlushE, Busy}, e.v);
            end
        end
    end
    task automatic cyc(input logic rs, input logic v, input logic [3:0] a1, input logic u1,
                       input logic [3:0] a2, input logic u2, input logic rw, input logic [3:0] wa,
                       input logic bt, input logic st, input logic fd, input logic fe,
                       input logic [15:0] bz, input string nm);
        @(posedge clk);
        #1;
        reset = rs; ValidD = v; ra1D = a1; Use1D = u1; ra2D = a2; Use2D = u2;
        RegWriteD = rw; wa3D = wa; BranchTakenE = bt;
        q.push_back('{{st, st, fd, fe, bz}, nm});
    endtask
    task automatic idle(input logic [15:0] bz, input string nm);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bz, nm);
    endtask
    task automatic wr(input logic [3:0] wa, input logic [15:0] bz, input string nm);
        cyc(0, 1, 0, 0, 0, 0, 1, wa, 0, 0, 0, 0, bz, nm);
    endtask
    initial begin
        // Two reset edges with junk on every input.
        repeat (2) begin
            ValidD = 1'($urandom); Use1D = 1'($urandom); Use2D = 1'($urandom);
            RegWriteD = 1'($urandom); BranchTakenE = 1'($urandom);
            ra1D = 4'($urandom); ra2D = 4'($urandom); wa3D = 4'($urandom);
            @(posedge clk);
            #1;
        end
        idle(16'h0000, "reset_release");
        wr(3, 16'h0000, "raw_issue");
        cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0008, "raw_stall_e");
        cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0008, "raw_stall_m");
        cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, "raw_proceed_w");
        idle(16'h0000, "raw_retired");
        wr(15, 16'h0000, "pc_write");
        cyc(0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, "pc_read");
        idle(16'h0000, "pc_untracked");
        wr(5, 16'h0000, "kill_issue");
        cyc(0, 1, 5, 1, 0, 0, 1, 6, 1, 0, 1, 1, 16'h0020, "kill_branch");
        cyc(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, "kill_read_free");
        wr(2, 16'h0000, "waw_0");
        cyc(0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0, 16'h0004, "waw_1_unused_src");
        wr(2, 16'h0004, "waw_2");
        wr(2, 16'h0004, "waw_3_with_retire");
        cyc(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 1, 16'h0004, "waw_cnt3_stall");
        cyc(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 1, 16'h0004, "waw_cnt2_stall");
        cyc(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 16'h0004, "waw_cnt1_go");
        idle(16'h0000, "waw_clear");
        wr(7, 16'h0000, "mid_7");
        wr(8, 16'h0080, "mid_8");
        wr(9, 16'h0180, "mid_9");
        cyc(1, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 16'h0380, "mid_reset");
        cyc(0, 1, 7, 1, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0000, "mid_after_reset");
        idle(16'h0000, "mid_idle");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
